// File: rtl/store_lane_buffer.sv
// Store path from EX/MEM to data memory: lane-aligns each store into one or two
// beats with byte enables and queues them in a DEPTH-entry FIFO drained by valid/ready.
module store_lane_buffer #(
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned SPLIT_MISALIGNED = 0,
  localparam int unsigned NB              = DATA_W / 8,
  localparam int unsigned OW              = $clog2(NB),
  localparam int unsigned CW              = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [NB-1:0]     mem_be,
  output logic              st_exc,
  output logic [ADDR_W-1:0] st_exc_addr,
  output logic [CW-1:0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [NB-1:0]     r_q_be   [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_count;
  logic              r_exc;
  logic [ADDR_W-1:0] r_exc_addr;

  logic [3:0]          w_off;
  logic [3:0]          w_bytes;
  logic                w_size_bad;
  logic                w_misal;
  logic                w_illegal;
  logic                w_cross;
  logic                w_acc;
  logic [1:0]          w_push_n;
  logic                w_pop;
  logic [2*NB-1:0]     w_be_wide;
  logic [2*DATA_W-1:0] w_shift;
  logic [2*DATA_W-1:0] w_data_wide;
  logic [ADDR_W-1:0]   w_addr_al;
  logic [ADDR_W-1:0]   w_addr_nx;

  always_comb begin
    w_off      = 4'(req_addr[OW-1:0]);
    w_bytes    = 4'd1 << req_size;
    w_size_bad = w_bytes > 4'(NB);
    w_misal    = |(w_off & (w_bytes - 4'd1));
    w_illegal  = w_size_bad || ((SPLIT_MISALIGNED == 0) && w_misal);
    w_cross    = (5'(w_off) + 5'(w_bytes)) > 5'(NB);
    w_acc      = req_valid && req_ready;
    w_pop      = (r_count != '0) && mem_ready;
    if (!w_acc || w_illegal) w_push_n = 2'd0;
    else if (w_cross)        w_push_n = 2'd2;
    else                     w_push_n = 2'd1;
  end

  // Enables and data are built across two adjacent lanes; the upper half is beat1 of a split.
  always_comb begin
    w_shift     = {{DATA_W{1'b0}}, req_data} << (8 * w_off);
    w_be_wide   = '0;
    w_data_wide = '0;
    for (int unsigned i = 0; i < 2 * NB; i++) begin
      w_be_wide[i] = (5'(i) >= 5'(w_off)) && (5'(i) < (5'(w_off) + 5'(w_bytes)));
      if (w_be_wide[i]) w_data_wide[8*i +: 8] = w_shift[8*i +: 8];
    end
    w_addr_al = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
    w_addr_nx = w_addr_al + ADDR_W'(NB);
  end

  always_ff @(posedge clk) begin
    if (w_push_n != 2'd0) begin
      r_q_addr[r_wp] <= w_addr_al;
      r_q_data[r_wp] <= w_data_wide[DATA_W-1:0];
      r_q_be[r_wp]   <= w_be_wide[NB-1:0];
    end
    if (w_push_n == 2'd2) begin
      r_q_addr[r_wp + PW'(1)] <= w_addr_nx;
      r_q_data[r_wp + PW'(1)] <= w_data_wide[2*DATA_W-1:DATA_W];
      r_q_be[r_wp + PW'(1)]   <= w_be_wide[2*NB-1:NB];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_exc      <= 1'b0;
      r_exc_addr <= '0;
    end else begin
      r_wp    <= r_wp + PW'(w_push_n);
      r_rp    <= r_rp + PW'(w_pop);
      r_count <= r_count + CW'(w_push_n) - CW'(w_pop);
      r_exc   <= w_acc && w_illegal;
      if (w_acc && w_illegal) r_exc_addr <= req_addr;
    end
  end

  // Ready needs room for two beats so a split never has to be checked against the request.
  always_comb begin
    req_ready   = r_count <= CW'(DEPTH - 2);
    mem_valid   = r_count != '0;
    mem_addr    = mem_valid ? r_q_addr[r_rp] : '0;
    mem_wdata   = mem_valid ? r_q_data[r_rp] : '0;
    mem_be      = mem_valid ? r_q_be[r_rp]   : '0;
    st_exc      = r_exc;
    st_exc_addr = r_exc_addr;
    count       = r_count;
  end

endmodule

// File: tb/tb_store_lane_buffer.sv
// Directed bench for store_lane_buffer (DATA_W=32, DEPTH=4): one instance with
// misaligned stores rejected, one with lane-crossing stores split into two beats.
module tb_store_lane_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid_s = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_data = '0;
  logic        mem_ready = 1'b0;

  logic        req_ready, mem_valid, st_exc;
  logic [31:0] mem_addr, mem_wdata, st_exc_addr;
  logic [3:0]  mem_be;
  logic [2:0]  count;

  logic        s_req_ready, s_mem_valid, s_st_exc;
  logic [31:0] s_mem_addr, s_mem_wdata, s_st_exc_addr;
  logic [3:0]  s_mem_be;
  logic [2:0]  s_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  store_lane_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .SPLIT_MISALIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .st_exc(st_exc),
    .st_exc_addr(st_exc_addr), .count(count)
  );

  store_lane_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .SPLIT_MISALIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .req_valid(req_valid_s), .req_ready(s_req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
    .mem_valid(s_mem_valid), .mem_ready(mem_ready), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_be(s_mem_be), .st_exc(s_st_exc),
    .st_exc_addr(s_st_exc_addr), .count(s_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    logic        exc;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic head(input string nm, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [2:0] cnt);
    chk({nm, ".valid"}, 64'(mem_valid), 64'(1));
    chk({nm, ".addr"},  64'(mem_addr),  64'(a));
    chk({nm, ".be"},    64'(mem_be),    64'(be));
    chk({nm, ".wdata"}, 64'(mem_wdata), 64'(wd));
    chk({nm, ".count"}, 64'(count),     64'(cnt));
  endtask

  task automatic s_head(input string nm, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [2:0] cnt);
    chk({nm, ".valid"}, 64'(s_mem_valid), 64'(1));
    chk({nm, ".addr"},  64'(s_mem_addr),  64'(a));
    chk({nm, ".be"},    64'(s_mem_be),    64'(be));
    chk({nm, ".wdata"}, 64'(s_mem_wdata), 64'(wd));
    chk({nm, ".count"}, 64'(s_count),     64'(cnt));
  endtask

  initial begin
    vecs[0] = '{32'h100, 2'd2, 32'h11223344, 1'b0, 32'h100,      4'b1111, 32'h11223344};
    vecs[1] = '{32'h103, 2'd0, 32'h000000AB, 1'b0, 32'h100,      4'b1000, 32'hAB000000};
    vecs[2] = '{32'h102, 2'd1, 32'h0000BEEF, 1'b0, 32'h100,      4'b1100, 32'hBEEF0000};
    vecs[3] = '{32'h201, 2'd0, 32'h0000005A, 1'b0, 32'h200,      4'b0010, 32'h00005A00};
    vecs[4] = '{32'h106, 2'd1, 32'h00001234, 1'b0, 32'h104,      4'b1100, 32'h12340000};
    vecs[5] = '{32'h101, 2'd1, 32'h00005555, 1'b1, 32'h101,      4'b0000, 32'h0};
    vecs[6] = '{32'h108, 2'd3, 32'h66666666, 1'b1, 32'h108,      4'b0000, 32'h0};
    vecs[7] = '{32'h10A, 2'd2, 32'h77777777, 1'b1, 32'h10A,      4'b0000, 32'h0};
    vecs[8] = '{32'hFFFFFFFF, 2'd0, 32'h00000077, 1'b0, 32'hFFFFFFFC, 4'b1000, 32'h77000000};

    // reset state
    #2;
    chk("rst.ready", 64'(req_ready), 64'(1));
    chk("rst.valid", 64'(mem_valid), 64'(0));
    chk("rst.addr",  64'(mem_addr),  64'(0));
    chk("rst.wdata", 64'(mem_wdata), 64'(0));
    chk("rst.be",    64'(mem_be),    64'(0));
    chk("rst.exc",   64'(st_exc),    64'(0));
    chk("rst.eaddr", 64'(st_exc_addr), 64'(0));
    chk("rst.count", 64'(count),     64'(0));
    @(negedge clk);
    reset = 1'b0;

    // table: one store at a time, then drain
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_addr = vecs[i].addr; req_size = vecs[i].size; req_data = vecs[i].data;
      req_valid = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      if (vecs[i].exc) begin
        chk($sformatf("v%0d.exc", i),   64'(st_exc),      64'(1));
        chk($sformatf("v%0d.eaddr", i), 64'(st_exc_addr), 64'(vecs[i].eaddr));
        chk($sformatf("v%0d.count", i), 64'(count),       64'(0));
        chk($sformatf("v%0d.valid", i), 64'(mem_valid),   64'(0));
        @(negedge clk);
        chk($sformatf("v%0d.exc_pulse", i), 64'(st_exc), 64'(0));
        chk($sformatf("v%0d.eaddr_hold", i), 64'(st_exc_addr), 64'(vecs[i].eaddr));
      end else begin
        head($sformatf("v%0d", i), vecs[i].eaddr, vecs[i].ebe, vecs[i].ewd, 3'd1);
        chk($sformatf("v%0d.noexc", i), 64'(st_exc), 64'(0));
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk($sformatf("v%0d.drain", i), 64'(count), 64'(0));
      end
    end

    // split: sw 0x102 becomes two beats in one cycle
    @(negedge clk);
    req_addr = 32'h102; req_size = 2'd2; req_data = 32'hAABBCCDD; req_valid_s = 1'b1;
    @(negedge clk);
    req_valid_s = 1'b0;
    s_head("sp0.b0", 32'h100, 4'b1100, 32'hCCDD0000, 3'd2);
    chk("sp0.noexc", 64'(s_st_exc), 64'(0));
    mem_ready = 1'b1;
    @(negedge clk);
    s_head("sp0.b1", 32'h104, 4'b0011, 32'h0000AABB, 3'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("sp0.drain", 64'(s_count), 64'(0));

    // split: sh 0x103 crosses with one byte in each lane
    req_addr = 32'h103; req_size = 2'd1; req_data = 32'h00001234; req_valid_s = 1'b1;
    @(negedge clk);
    req_valid_s = 1'b0;
    s_head("sp1.b0", 32'h100, 4'b1000, 32'h34000000, 3'd2);
    mem_ready = 1'b1;
    @(negedge clk);
    s_head("sp1.b1", 32'h104, 4'b0001, 32'h00000012, 3'd1);
    @(negedge clk);
    mem_ready = 1'b0;

    // split instance still rejects dword on a 32-bit lane
    req_addr = 32'h200; req_size = 2'd3; req_data = 32'h1; req_valid_s = 1'b1;
    @(negedge clk);
    req_valid_s = 1'b0;
    chk("sp2.exc",   64'(s_st_exc),      64'(1));
    chk("sp2.eaddr", 64'(s_st_exc_addr), 64'(32'h200));
    chk("sp2.count", 64'(s_count),       64'(0));

    // fill: four back-to-back sw, only three fit
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_addr = 32'h300 + 32'(4 * i); req_size = 2'd2; req_data = 32'hA0 + 32'(i);
      req_valid = 1'b1;
    end
    @(negedge clk);
    req_valid = 1'b0;
    head("full", 32'h300, 4'b1111, 32'hA0, 3'd3);
    chk("full.ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    head("stall", 32'h300, 4'b1111, 32'hA0, 3'd3);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    head("pop1", 32'h304, 4'b1111, 32'hA1, 3'd2);
    chk("pop1.ready", 64'(req_ready), 64'(1));
    req_addr = 32'h310; req_data = 32'hA4; req_valid = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b0;
    head("pushpop", 32'h308, 4'b1111, 32'hA2, 3'd2);
    req_addr = 32'h314; req_data = 32'hA5; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("refill.count", 64'(count), 64'(3));

    // asynchronous reset mid-cycle drops everything
    #2 reset = 1'b1;
    #1;
    chk("areset.count", 64'(count),     64'(0));
    chk("areset.valid", 64'(mem_valid), 64'(0));
    chk("areset.ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    req_addr = 32'h400; req_size = 2'd2; req_data = 32'hCAFEF00D; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    head("post", 32'h400, 4'b1111, 32'hCAFEF00D, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
